// File: rtl/flow_fifo_param.sv
// flow_fifo_param: parametrised synchronous FIFO with almost-empty/full thresholds,
// sticky overflow/underflow flags, occupancy and peak-occupancy monitor.
module flow_fifo_param #(
  parameter int DATA_W = 6,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic [ADDR_W:0]   th_empty,
  input  logic [ADDR_W:0]   th_full,
  input  logic              err_clr,
  output logic              empty,
  output logic              full,
  output logic              almost_empty,
  output logic              almost_full,
  output logic [ADDR_W:0]   occupancy,
  output logic [ADDR_W:0]   peak,
  output logic              overflow_err,
  output logic              underflow_err
);
  localparam logic [ADDR_W:0] DEPTH_C = {1'b1, {ADDR_W{1'b0}}};
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count, count_nxt;
  logic              push_ok, pop_ok;
  assign empty        = count == '0;
  assign full         = count == DEPTH_C;
  assign occupancy    = count;
  assign almost_empty = count <= th_empty;
  assign almost_full  = (th_full != '0) && (count >= th_full);
  assign push_ok      = wr_en & ~full;
  assign pop_ok       = rd_en & ~empty;
  assign count_nxt    = count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
  always_ff @(posedge clk)
    if (push_ok) mem[wr_ptr] <= wr_data;
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      rd_data       <= '0;
      rd_valid      <= 1'b0;
      peak          <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok) begin
        rd_ptr  <= rd_ptr + 1'b1;
        rd_data <= mem[rd_ptr];
      end
      rd_valid      <= pop_ok;
      count         <= count_nxt;
      peak          <= err_clr ? count : (count_nxt > peak ? count_nxt : peak);
      overflow_err  <= (overflow_err & ~err_clr) | (wr_en & full);
      underflow_err <= (underflow_err & ~err_clr) | (rd_en & empty);
    end
  end
endmodule

// File: tb/tb_flow_fifo_param.sv
// tb_flow_fifo_param: queue-model scoreboard bench for flow_fifo_param (DATA_W=6, ADDR_W=3).
module tb_flow_fifo_param;
  logic       clk = 0, reset = 0, wr_en = 0, rd_en = 0, err_clr = 0;
  logic [5:0] wr_data = 0, rd_data;
  logic       rd_valid, empty, full, almost_empty, almost_full, overflow_err, underflow_err;
  logic [3:0] th_empty = 4'd8, th_full = 4'd9, occupancy, peak;
  int checks = 0, failures = 0;
  logic [5:0] mq[$], sb[$];
  int m_cnt = 0, m_peak = 0;
  bit m_ovf = 0, m_udf = 0, m_valid = 0;
  logic [5:0] m_rd = 0;

  flow_fifo_param #(.DATA_W(6), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid), .th_empty(th_empty), .th_full(th_full),
    .err_clr(err_clr), .empty(empty), .full(full), .almost_empty(almost_empty),
    .almost_full(almost_full), .occupancy(occupancy), .peak(peak),
    .overflow_err(overflow_err), .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    bit pu, po;
    int old_cnt;
    old_cnt = m_cnt;
    pu = wr_en && m_cnt < 8;
    po = rd_en && m_cnt > 0;
    if (!reset) begin
      mq.delete(); sb.delete();
      m_cnt = 0; m_peak = 0; m_ovf = 0; m_udf = 0; m_valid = 0; m_rd = 0;
    end else begin
      m_ovf = (m_ovf && !err_clr) || (wr_en && m_cnt == 8);
      m_udf = (m_udf && !err_clr) || (rd_en && m_cnt == 0);
      if (po) begin
        m_rd = mq.pop_front();
        sb.push_back(m_rd);
      end
      if (pu) mq.push_back(wr_data);
      m_cnt = mq.size();
      m_valid = po;
      m_peak = err_clr ? old_cnt : (m_cnt > m_peak ? m_cnt : m_peak);
    end
    @(posedge clk); #1;
    chk("rd_valid", rd_valid, m_valid);
    if (rd_valid) begin
      if (sb.size() == 0) chk("sb_underrun", 1, 0);
      else chk("rd_data", rd_data, sb.pop_front());
    end
    chk("rd_data_hold", rd_data, m_rd);
    chk("occupancy", occupancy, m_cnt);
    chk("empty", empty, m_cnt == 0);
    chk("full", full, m_cnt == 8);
    chk("almost_empty", almost_empty, m_cnt <= th_empty);
    chk("almost_full", almost_full, th_full != 0 && m_cnt >= th_full);
    chk("peak", peak, m_peak);
    chk("overflow_err", overflow_err, m_ovf);
    chk("underflow_err", underflow_err, m_udf);
  endtask

  task automatic drive(input bit w, input logic [5:0] d, input bit r, input bit c);
    wr_en = w; wr_data = d; rd_en = r; err_clr = c;
    cycle();
    wr_en = 0; rd_en = 0; err_clr = 0;
  endtask

  initial begin
    reset = 0;
    drive(0, 0, 0, 0);
    drive(1, 6'h2a, 1, 0);
    chk("rst_empty", empty, 1);
    chk("rst_rd_data", rd_data, 0);
    reset = 1;
    for (int i = 1; i <= 8; i++) drive(1, 6'(i), 0, 0);
    chk("fill_occ", occupancy, 8);
    chk("fill_full", full, 1);
    chk("fill_peak", peak, 8);
    chk("fill_af_disabled", almost_full, 0);
    for (int i = 1; i <= 8; i++) begin
      drive(0, 0, 1, 0);
      chk("drain_order", rd_data, i);
    end
    chk("drain_empty", empty, 1);
    for (int i = 0; i < 8; i++) drive(1, 6'(i + 16), 0, 0);
    drive(1, 6'h3f, 1, 0);
    chk("ovf_set", overflow_err, 1);
    chk("ovf_occ", occupancy, 7);
    drive(0, 0, 0, 1);
    chk("ovf_clr", overflow_err, 0);
    chk("clr_peak", peak, 7);
    for (int i = 0; i < 7; i++) drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    chk("udf_set", underflow_err, 1);
    chk("udf_no_valid", rd_valid, 0);
    drive(0, 0, 1, 1);
    chk("udf_set_wins", underflow_err, 1);
    drive(0, 0, 0, 1);
    chk("udf_clr", underflow_err, 0);
    th_empty = 4'd2; th_full = 4'd6;
    for (int i = 0; i < 6; i++) begin
      drive(1, 6'(i + 32), 0, 0);
      if (i == 2) chk("ae_drop", almost_empty, 0);
      if (i == 4) chk("af_not_yet", almost_full, 0);
    end
    chk("af_rise", almost_full, 1);
    th_full = 4'd0; #1;
    chk("af_off", almost_full, 0);
    drive(0, 0, 1, 0);
    drive(0, 0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      drive(1, 6'($urandom_range(0, 63)), 1, 0);
      chk("stream_occ", occupancy, 4);
    end
    wr_en = 1; rd_en = 1; reset = 0;
    cycle();
    chk("midrst_empty", empty, 1);
    chk("midrst_valid", rd_valid, 0);
    reset = 1; wr_en = 0; rd_en = 0;
    drive(0, 0, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/flow_fifo_param.md
Name: flow_fifo_param

Overview:
Parametrised synchronous FIFO for the flow-control path. It generalises the fixed 6-bit main FIFO to configurable data width and power-of-two depth. It supports simultaneous push/pop and programmable almost-empty/almost-full thresholds for the upstream/downstream flow-control logic. It also provides sticky overflow/underflow error flags, an occupancy output and a peak-occupancy (high-water) monitor.

Parameters:
DATA_W, 6, data word width in bits
ADDR_W, 3, address width; DEPTH = 2**ADDR_W entries (default 8)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset
wr_en  input  1  push request
wr_data  input  DATA_W  push data
rd_en  input  1  pop request
rd_data  output  DATA_W  popped word, registered
rd_valid  output  1  rd_data holds a newly popped word this cycle
th_empty  input  ADDR_W+1  almost-empty threshold
th_full  input  ADDR_W+1  almost-full threshold; 0 disables almost_full
err_clr  input  1  clears sticky error flags and peak monitor
empty  output  1  occupancy == 0
full  output  1  occupancy == DEPTH
almost_empty  output  1  occupancy <= th_empty
almost_full  output  1  th_full != 0 and occupancy >= th_full
occupancy  output  ADDR_W+1  number of stored words
peak  output  ADDR_W+1  highest occupancy since last reset/err_clr
overflow_err  output  1  sticky; push attempted while full
underflow_err  output  1  sticky; pop attempted while empty

Behaviour:
- Reset: reset is synchronous, active-low, sampled on clk rising edge.
  - Register values: wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, peak=0, overflow_err=0, underflow_err=0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored words and any pending read in the same edge.
- Accept rules:
  - push_ok = wr_en & ~full.
  - pop_ok = rd_en & ~empty.
  - Both use the registered count of the current cycle; there is no write-through on full and no read-through on empty.
- Push: mem[wr_ptr] <= wr_data; wr_ptr <= wr_ptr+1, wrapping modulo DEPTH.
- Pop: rd_data <= mem[rd_ptr]; rd_ptr <= rd_ptr+1, wrapping; rd_valid <= 1 on the next edge.
  - Read latency is 1 cycle. rd_valid is 0 in any cycle after a non-accepted pop.
  - rd_data holds its last value when no pop occurs.
- Count update:
  - push_ok only: +1.
  - pop_ok only: -1.
  - both or neither: unchanged.
  - Simultaneous push and pop at 0 < count < DEPTH: both occur, count constant.
- Boundaries:
  - count==0 with wr_en & rd_en: push only (pop rejected), underflow_err set.
  - count==DEPTH with wr_en & rd_en: pop only (push rejected, data dropped), overflow_err set.
- Status outputs (empty, full, almost_empty, almost_full, occupancy) are combinational decodes of registered count; they change in the cycle after the accepting edge.
- Thresholds:
  - Compared live each cycle as unsigned values.
  - th_empty >= DEPTH forces almost_empty=1.
  - th_full > DEPTH forces almost_full=0.
- Errors:
  - overflow_err set on wr_en & full; underflow_err set on rd_en & empty.
  - Both flags stay set until err_clr=1. If set and clear occur in the same cycle, set wins.
- Peak:
  - peak <= max(peak, next count) each edge.
  - err_clr loads peak with the current count.

Test Plan:
- Reset, then 8 pushes of 0x01..0x08 (DATA_W=6, ADDR_W=3) -> occupancy 8, full=1, empty=0, peak=8, no errors.
- From full, 8 pops -> rd_data 0x01..0x08 in order, each rd_valid one cycle after rd_en; then empty=1, occupancy=0.
- Full FIFO, wr_en=rd_en=1 for 1 cycle -> push dropped, overflow_err=1, occupancy 7. err_clr -> overflow_err=0, peak=7.
- Empty FIFO, rd_en=1 -> rd_valid stays 0, underflow_err=1, empty stays 1. Same-cycle err_clr and rd_en -> underflow_err remains 1.
- th_empty=2, th_full=6, push 6 words one per cycle -> almost_empty drops after 3rd push, almost_full rises after 6th. Set th_full=0 -> almost_full=0 immediately.
- Occupancy 4 with continuous simultaneous push/pop for 20 cycles (pointers wrap twice) -> occupancy constant 4, output order equals input order, reset=0 mid-stream -> next cycle empty=1, rd_valid=0.
